// File: rtl/serial_adder_dec.sv
// rtl/serial_adder_dec.sv - LSB-first bit-serial add/subtract unit built on a 3-to-8 minterm decoder.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder_dec #(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic             carry;
   logic [CNT_W-1:0] cnt;
   logic [7:0]       m;
   logic             s_bit;
   logic             c_bit;

   // Single minterm decoder shared by the sum and carry functions.
   always_comb begin
      m        = 8'd0;
      m[{a_sr[0], b_sr[0], carry}] = 1'b1;
      s_bit    = m[1] | m[2] | m[4] | m[7];
      c_bit    = m[3] | m[5] | m[6] | m[7];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
         carry <= 1'b0;
         cnt   <= '0;
         a_sr  <= '0;
         b_sr  <= '0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  // Subtract is A + ~B + 1, so cin is replaced by a forced carry.
                  a_sr  <= a;
                  b_sr  <= sub ? ~b : b;
                  carry <= sub ? 1'b1 : cin;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               a_sr  <= a_sr >> 1;
               b_sr  <= b_sr >> 1;
               carry <= c_bit;
               sum   <= {s_bit, sum[WIDTH-1:1]};
               cnt   <= cnt + 1'b1;
               if (cnt == LAST) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  cout  <= c_bit;
`ifdef SERIAL_ADDER_OVF_EN
                  // carry still holds the carry into the MSB during the last step.
                  ovf   <= carry ^ c_bit;
`endif
                  state <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder_dec.sv
// tb/tb_serial_adder_dec.sv - table, hand-sequence and random checks for serial_adder_dec.
module tb_serial_adder_dec;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         sub = 1'b0;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
   logic         ovf;
`endif

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   serial_adder_dec #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .sub   (sub),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sub;
      logic [W-1:0] s;
      logic         c;
      logic         o;
   } vec_t;

   vec_t tbl[8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: whole-word arithmetic, signed overflow from operand/result signs.
   function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                                 input logic s, output logic [W-1:0] rs, output logic rc,
                                 output logic ro);
      logic [W:0]   full;
      logic [W-1:0] yy;
      logic         c;
      yy   = s ? ~y : y;
      c    = s ? 1'b1 : ci;
      full = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, c};
      rs   = full[W-1:0];
      rc   = full[W];
      ro   = (x[W-1] == yy[W-1]) && (rs[W-1] != x[W-1]);
   endfunction

   task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                         input logic s, output int acc);
      a = x; b = y; cin = ci; sub = s; start = 1'b1;
      tick();
      start = 1'b0;
      acc = cyc;
   endtask

   task automatic wait_done(output int at, output int bcnt);
      int n;
      n = 0;
      bcnt = 0;
      while (!done && n < 40) begin
         if (busy) bcnt++;
         tick();
         n++;
      end
      at = cyc;
   endtask

   task automatic run_check(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic ci, input logic s, input logic [W-1:0] es,
                            input logic ec, input logic eo);
      int acc, at, bcnt;
      launch(x, y, ci, s, acc);
      wait_done(at, bcnt);
      check({tag, " done"}, done, 1'b1);
      check({tag, " latency"}, at - acc, W);
      check({tag, " busy cycles"}, bcnt, W);
      check({tag, " sum"}, sum, es);
      check({tag, " cout"}, cout, ec);
`ifdef SERIAL_ADDER_OVF_EN
      check({tag, " ovf"}, ovf, eo);
`else
      if (eo === 1'bx) check({tag, " ovf ref"}, eo, 1'b0);
`endif
      tick();
      check({tag, " done pulse"}, done, 1'b0);
   endtask

   initial begin
      int acc, at, at2, bcnt, dcount;
      logic [W-1:0] rs, x, y;
      logic rc, ro, ci, s;

      tbl[0] = '{8'h3C, 8'h0F, 1'b0, 1'b0, 8'h4B, 1'b0, 1'b0};
      tbl[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
      tbl[2] = '{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
      tbl[3] = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0};
      tbl[4] = '{8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0};
      tbl[5] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
      tbl[6] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
      tbl[7] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};

      #12;
      check("reset busy", busy, 1'b0);
      check("reset done", done, 1'b0);
      check("reset sum", sum, 8'h00);
      check("reset cout", cout, 1'b0);
`ifdef SERIAL_ADDER_OVF_EN
      check("reset ovf", ovf, 1'b0);
`endif
      @(posedge clk); #1;
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 8; i++)
         run_check($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub,
                   tbl[i].s, tbl[i].c, tbl[i].o);

      // start during busy cycle 3 must be ignored
      launch(8'h3C, 8'h0F, 1'b0, 1'b0, acc);
      tick(); tick();
      a = 8'hFF; b = 8'hFF; sub = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(at, bcnt);
      check("ignored start latency", at - acc, W);
      check("ignored start sum", sum, 8'h4B);
      check("ignored start cout", cout, 1'b0);
      tick();
      check("ignored start idle", busy, 1'b0);

      // start held high: back-to-back operations with no IDLE gap
      a = 8'h01; b = 8'h02; cin = 1'b0; sub = 1'b0; start = 1'b1;
      tick();
      acc = cyc;
      a = 8'h10; b = 8'h20;
      wait_done(at, bcnt);
      check("b2b first latency", at - acc, W);
      check("b2b first sum", sum, 8'h03);
      tick();
      check("b2b done drop", done, 1'b0);
      check("b2b busy rise", busy, 1'b1);
      wait_done(at2, bcnt);
      start = 1'b0;
      check("b2b done spacing", at2 - at, W + 1);
      check("b2b second sum", sum, 8'h30);
      tick();
      check("b2b idle done", done, 1'b0);
      check("b2b idle busy", busy, 1'b0);

      // asynchronous reset mid-operation
      launch(8'h12, 8'h34, 1'b0, 1'b0, acc);
      tick(); tick(); tick();
      #2 rst_n = 1'b0;
      #1;
      check("abort busy", busy, 1'b0);
      check("abort done", done, 1'b0);
      check("abort sum", sum, 8'h00);
      check("abort cout", cout, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      dcount = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (done) dcount++;
      end
      check("abort no done", dcount, 0);
      run_check("after abort", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);

      for (int i = 0; i < 24; i++) begin
         x  = W'($urandom);
         y  = W'($urandom);
         ci = 1'($urandom);
         s  = 1'($urandom);
         model(x, y, ci, s, rs, rc, ro);
         run_check($sformatf("rand%0d", i), x, y, ci, s, rs, rc, ro);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
